// File: rtl/booth_pkg.sv
// booth_pkg -- shared definitions for the sequential Booth multiplier.
//   state_t    : controller states IDLE / CALC / DONE
//   digit_t    : recoded Booth digit; bit 2 set means "subtract"
//   booth_iter : number of digit iterations for a given WIDTH and radix
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'b000,
    DIG_P1   = 3'b001,
    DIG_P2   = 3'b010,
    DIG_M1   = 3'b101,
    DIG_M2   = 3'b110
  } digit_t;

  // One extra digit covers the extension bits, so unsigned operands with
  // the MSB set still recode correctly.
  function automatic int unsigned booth_iter(input int unsigned width,
                                             input bit          radix4);
    return radix4 ? (width / 2 + 1) : (width + 1);
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// booth_recoder -- maps a multiplier window to a Booth digit.
//   WIN_BITS = 2 : radix-2 window {q[i], q[i-1]},            digits {-1,0,+1}
//   WIN_BITS = 3 : radix-4 window {q[i+1], q[i], q[i-1]},    digits {-2..+2}
// Ports:
//   i_window : current multiplier window (LSB is the previously examined bit)
//   o_digit  : digit code consumed by the accumulate datapath
module booth_recoder
  import booth_pkg::*;
#(
  parameter int unsigned WIN_BITS = 2
) (
  input  logic [WIN_BITS-1:0] i_window,
  output digit_t              o_digit
);

  generate
    if (WIN_BITS == 3) begin : g_radix4
      always_comb begin
        o_digit = DIG_ZERO;
        case (i_window)
          3'b001, 3'b010: o_digit = DIG_P1;
          3'b011:         o_digit = DIG_P2;
          3'b100:         o_digit = DIG_M2;
          3'b101, 3'b110: o_digit = DIG_M1;
          default:        o_digit = DIG_ZERO;
        endcase
      end
    end else begin : g_radix2
      always_comb begin
        o_digit = DIG_ZERO;
        case (i_window)
          2'b01:   o_digit = DIG_P1;
          2'b10:   o_digit = DIG_M1;
          default: o_digit = DIG_ZERO;
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq -- sequential Booth multiplier, one digit per cycle,
// valid/ready handshake on both sides.
// Build option: define BOOTH_MUL_RADIX4_EN for radix-4 recoding
// (WIDTH/2+1 iterations); otherwise radix-2 (WIDTH+1 iterations).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high in IDLE only)
//   multiplicand (M)     : WIDTH-bit operand
//   multiplier   (Q)     : WIDTH-bit operand
//   signed_mode          : 1 = two's complement, 0 = unsigned
//   out_valid / out_ready: result handshake
//   product              : 2*WIDTH-bit exact product
module booth_multiplier_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

`ifdef BOOTH_MUL_RADIX4_EN
  localparam bit RADIX4 = 1'b1;
`else
  localparam bit RADIX4 = 1'b0;
`endif

  localparam int unsigned SHIFT = RADIX4 ? 2 : 1;
  localparam int unsigned WIN   = SHIFT + 1;
  localparam int unsigned QX_W  = WIDTH + SHIFT;
  localparam int unsigned ACC_W = 2 * WIDTH + 2;
  localparam int unsigned ITER  = booth_iter(WIDTH, RADIX4);
  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_m;
  logic [QX_W:0]    r_q;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] w_m_ext;
  logic [QX_W-1:0]  w_q_ext;
  logic [ACC_W-1:0] w_addend;
  digit_t           w_digit;
  logic             w_accept;
  logic             w_unused;

  assign w_accept = in_valid && r_in_ready;

  // Extension is chosen by the mode sampled with the operands.
  assign w_m_ext = {{(ACC_W - WIDTH){signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
  assign w_q_ext = {{SHIFT{signed_mode & multiplier[WIDTH-1]}}, multiplier};

  // r_q holds {extended Q, 0}; its low WIN bits are always the current
  // window, and it shifts right by one digit per iteration.
  booth_recoder #(
    .WIN_BITS (WIN)
  ) u_recoder (
    .i_window (r_q[WIN-1:0]),
    .o_digit  (w_digit)
  );

  // r_m is M pre-shifted to the current digit weight; arithmetic is modulo
  // 2^ACC_W, which is exact for the low 2*WIDTH product bits.
  always_comb begin
    w_addend = '0;
    case (w_digit)
      DIG_P1:  w_addend = r_m;
      DIG_M1:  w_addend = -r_m;
      DIG_P2:  w_addend = r_m << 1;
      DIG_M2:  w_addend = -(r_m << 1);
      default: w_addend = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)       w_state_nxt = CALC;
      CALC:    if (r_cnt == LAST)  w_state_nxt = DONE;
      DONE:    if (out_ready)      w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_acc      <= '0;
      r_m        <= '0;
      r_q        <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // Registered so in_ready stays low through reset and rises on the
      // first edge after it.
      r_in_ready <= (w_state_nxt == IDLE);
      if (w_accept) begin
        r_m   <= w_m_ext;
        r_q   <= {w_q_ext, 1'b0};
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        r_acc <= r_acc + w_addend;
        r_m   <= r_m << SHIFT;
        r_q   <= r_q >> SHIFT;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == DONE);
  assign product   = r_acc[2*WIDTH-1:0];

  // Guard bits of the accumulator never reach the output.
  assign w_unused  = ^r_acc[ACC_W-1 -: 2];

endmodule

// File: tb/tb_booth_multiplier_seq.sv
module tb_booth_multiplier_seq;

  localparam int unsigned W = 8;
`ifdef BOOTH_MUL_RADIX4_EN
  localparam int unsigned ITER = W / 2 + 1;
`else
  localparam int unsigned ITER = W + 1;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           signed_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int             total;
  int             bad;
  logic [2*W-1:0] sb_q[$];

  booth_multiplier_seq #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .signed_mode  (signed_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] gold(input logic [W-1:0] m,
                                          input logic [W-1:0] q,
                                          input logic         s);
    logic signed [2*W-1:0] sm;
    logic signed [2*W-1:0] sq;
    if (s) begin
      sm = $signed({{W{m[W-1]}}, m});
      sq = $signed({{W{q[W-1]}}, q});
      return sm * sq;
    end
    return {{W{1'b0}}, m} * {{W{1'b0}}, q};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic s, input int unsigned stall);
    int unsigned    cyc;
    logic           got;
    logic           ir_bad;
    logic [2*W-1:0] exp_p;
    multiplicand = m;
    multiplier   = q;
    signed_mode  = s;
    in_valid     = 1'b1;
    out_ready    = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 50) begin
      got = in_ready;
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (got !== 1'b1) begin
      bad++;
      $error("FAIL accept observed=%h expected=%h", got, 1'b1);
    end
    if (!got) return;
    sb_q.push_back(gold(m, q, s));
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
    signed_mode  = ~s;
    ir_bad = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      if (in_ready) ir_bad = 1'b1;
      tick;
      cyc++;
    end
    total++;
    if (cyc !== ITER) begin
      bad++;
      $error("FAIL latency observed=%0d expected=%0d", cyc, ITER);
    end
    total++;
    if (ir_bad !== 1'b0) begin
      bad++;
      $error("FAIL calc_in_ready observed=%h expected=%h", ir_bad, 1'b0);
    end
    for (int unsigned k = 0; k < stall; k++) begin
      if (k == 2) begin
        in_valid     = 1'b1;
        multiplicand = 8'h11;
        multiplier   = 8'h22;
      end else begin
        in_valid = 1'b0;
      end
      tick;
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $error("FAIL stall_valid observed=%h expected=%h", out_valid, 1'b1);
      end
      total++;
      if (product !== sb_q[0]) begin
        bad++;
        $error("FAIL stall_product observed=%h expected=%h", product, sb_q[0]);
      end
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $error("FAIL stall_in_ready observed=%h expected=%h", in_ready, 1'b0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_p = sb_q.pop_front();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $error("FAIL out_valid observed=%h expected=%h", out_valid, 1'b1);
    end
    total++;
    if (product !== exp_p) begin
      bad++;
      $error("FAIL product observed=%h expected=%h", product, exp_p);
    end
    tick;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $error("FAIL release_valid observed=%h expected=%h", out_valid, 1'b0);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $error("FAIL bubble_in_ready observed=%h expected=%h", in_ready, 1'b1);
    end
  endtask

  task automatic b2b(input logic mode, input int unsigned n);
    int unsigned    accepts;
    int unsigned    cyc;
    int unsigned    last_acc;
    int unsigned    budget;
    logic           first;
    logic           will_acc;
    logic           will_out;
    logic [2*W-1:0] exp_p;
    accepts  = 0;
    cyc      = 0;
    last_acc = 0;
    first    = 1'b1;
    budget   = n * (ITER + 2) + 50;
    signed_mode  = mode;
    out_ready    = 1'b1;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
    in_valid     = 1'b1;
    while ((accepts < n || sb_q.size() != 0) && cyc < budget) begin
      will_acc = in_ready && in_valid;
      will_out = out_valid;
      if (will_out) begin
        exp_p = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
        total++;
        if (product !== exp_p) begin
          bad++;
          $error("FAIL b2b_product observed=%h expected=%h", product, exp_p);
        end
      end
      if (will_acc) begin
        sb_q.push_back(gold(multiplicand, multiplier, mode));
        if (!first) begin
          total++;
          if (cyc - last_acc !== ITER + 2) begin
            bad++;
            $error("FAIL b2b_interval observed=%0d expected=%0d",
                   cyc - last_acc, ITER + 2);
          end
        end
        first    = 1'b0;
        last_acc = cyc;
        accepts++;
      end
      tick;
      cyc++;
      if (will_acc) begin
        if (accepts < n) begin
          multiplicand = 8'($urandom);
          multiplier   = 8'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (accepts !== n) begin
      bad++;
      $error("FAIL b2b_accepts observed=%0d expected=%0d", accepts, n);
    end
    total++;
    if (sb_q.size() !== 0) begin
      bad++;
      $error("FAIL b2b_drained observed=%0d expected=%0d", sb_q.size(), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic flag;
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    signed_mode  = 1'b0;
    out_ready    = 1'b0;

    #3;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $error("FAIL rst_in_ready observed=%h expected=%h", in_ready, 1'b0);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $error("FAIL rst_out_valid observed=%h expected=%h", out_valid, 1'b0);
    end
    total++;
    if (product !== 16'h0000) begin
      bad++;
      $error("FAIL rst_product observed=%h expected=%h", product, 16'h0000);
    end
    tick;
    tick;
    rst_n = 1'b1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $error("FAIL post_rst_in_ready_low observed=%h expected=%h", in_ready, 1'b0);
    end
    tick;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $error("FAIL post_rst_in_ready_high observed=%h expected=%h", in_ready, 1'b1);
    end

    run_op(8'h80, 8'h80, 1'b1, 0);
    run_op(8'hFF, 8'hFF, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'hFF, 8'h7F, 1'b1, 5);
    run_op(8'h7F, 8'h80, 1'b1, 0);
    run_op(8'h00, 8'hAB, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 2);

    multiplicand = 8'h12;
    multiplier   = 8'h34;
    signed_mode  = 1'b1;
    in_valid     = 1'b1;
    tick;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $error("FAIL abort_accepted observed=%h expected=%h", in_ready, 1'b0);
    end
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $error("FAIL abort_rst_out_valid observed=%h expected=%h", out_valid, 1'b0);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $error("FAIL abort_rst_in_ready observed=%h expected=%h", in_ready, 1'b0);
    end
    total++;
    if (product !== 16'h0000) begin
      bad++;
      $error("FAIL abort_rst_product observed=%h expected=%h", product, 16'h0000);
    end
    tick;
    rst_n = 1'b1;
    flag = 1'b0;
    for (int unsigned k = 0; k < ITER + 4; k++) begin
      if (out_valid) flag = 1'b1;
      tick;
    end
    total++;
    if (flag !== 1'b0) begin
      bad++;
      $error("FAIL abort_no_stale_valid observed=%h expected=%h", flag, 1'b0);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $error("FAIL abort_in_ready observed=%h expected=%h", in_ready, 1'b1);
    end
    run_op(8'h03, 8'h05, 1'b0, 0);

    b2b(1'b0, 1000);
    b2b(1'b1, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
